// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128/192/256 definitions.
// Holds the 128-bit state type, the FSM state encoding, the S-box table,
// the round-constant table and the GF(2^8) helpers used by the key expansion
// and the round datapath.
package aes_pkg;

    typedef logic [127:0] state_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        KEYEXP = 3'd1,
        ROUND  = 3'd2,
        DONE   = 3'd3
    } fsm_state_e;

    // Forward S-box, entry 0 in the top byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry x lives at bit offset (255-x)*8, i.e. {~x, 3'b000}.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TABLE[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Round constant Rcon[idx], idx = 1..10.
    function automatic logic [7:0] rcon(input logic [3:0] idx);
        logic [7:0] r;
        case (idx)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // MixColumns on one column {a0,a1,a2,a3}, a0 in the top byte.
    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

endpackage

// File: rtl/aes_enc_round.sv
// aes_enc_round: one combinational AES encryption round.
// SubBytes -> ShiftRows -> MixColumns (skipped when final_round) -> AddRoundKey.
// Byte n of the state is state[127-8n -: 8]; column c holds bytes 4c..4c+3.
module aes_enc_round
    import aes_pkg::*;
(
    input  state_t state,
    input  state_t round_key,
    input  logic   final_round,
    output state_t next_state
);

    state_t sb_w;
    state_t sr_w;
    state_t mc_w;

    // SubBytes on all 16 bytes
    always_comb begin
        sb_w = '0;
        for (int n = 0; n < 16; n++) begin
            sb_w[127-8*n -: 8] = sbox(state[127-8*n -: 8]);
        end
    end

    // ShiftRows: row r rotates left by r columns
    always_comb begin
        sr_w = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr_w[127-8*(4*c+r) -: 8] = sb_w[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
    end

    // MixColumns on each of the four columns
    always_comb begin
        mc_w = '0;
        for (int c = 0; c < 4; c++) begin
            mc_w[127-32*c -: 32] = mix_column(sr_w[127-32*c -: 32]);
        end
    end

    assign next_state = (final_round ? sr_w : mc_w) ^ round_key;

endmodule

// File: rtl/aes_encrypt_iter.sv
// aes_encrypt_iter: iterative FIPS-197 AES encryption, one round per cycle.
// Accept (in_valid & in_ready) loads the whitened state and the key words,
// KEYEXP expands one key word per cycle, ROUND runs Nr rounds, DONE holds ct
// until ct_ready. Build option AES_KEY_CACHE_EN keeps the last expanded key
// and skips KEYEXP when the next request carries the same key.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid stays high and its data stable until that edge.
module aes_encrypt_iter
    import aes_pkg::*;
#(
    parameter int Nk = 4,
    parameter int Nr = Nk + 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [32*Nk-1:0]  key,
    input  logic [127:0]      pt,
    output logic              ct_valid,
    input  logic              ct_ready,
    output logic [127:0]      ct,
    output logic [2:0]        dbg_state_o
);

    localparam int NW     = 4 * (Nr + 1);
    localparam int WIDX_W = $clog2(NW);

    fsm_state_e        fsm_q;
    logic              in_ready_q;
    logic              ct_valid_q;
    state_t            ct_q;
    state_t            state_q;
    logic [31:0]       w_q [NW];
    logic [WIDX_W-1:0] widx_q;
    logic [2:0]        kmod_q;
    logic [3:0]        rcon_idx_q;
    logic [3:0]        round_q;

    logic              accept;
    logic              cache_hit;
    logic [WIDX_W-1:0] idx_prev;
    logic [WIDX_W-1:0] idx_back;
    logic [31:0]       w_prev;
    logic [31:0]       w_back;
    logic [31:0]       temp_w;
    logic [31:0]       w_new;
    logic [WIDX_W-1:0] rk_base;
    state_t            round_key;
    state_t            round_out;
    logic              final_round;
    logic              last_word;
    logic              kmod_last;

    assign accept      = in_valid & in_ready_q;
    assign idx_prev    = widx_q - WIDX_W'(1);
    assign idx_back    = widx_q - WIDX_W'(Nk);
    assign w_prev      = w_q[idx_prev];
    assign w_back      = w_q[idx_back];
    assign last_word   = (widx_q == WIDX_W'(NW - 1));
    assign kmod_last   = (kmod_q == 3'(Nk - 1));
    assign final_round = (round_q == 4'(Nr));

    // Key-schedule temp word for index widx_q (kmod_q = widx_q mod Nk)
    always_comb begin
        temp_w = w_prev;
        if (kmod_q == 3'd0) begin
            temp_w = sub_word({w_prev[23:0], w_prev[31:24]}) ^ {rcon(rcon_idx_q), 24'h000000};
        end else if (Nk == 8 && kmod_q == 3'd4) begin
            temp_w = sub_word(w_prev);
        end
    end

    assign w_new = w_back ^ temp_w;

    assign rk_base   = WIDX_W'({round_q, 2'b00});
    assign round_key = {w_q[rk_base], w_q[rk_base + WIDX_W'(1)],
                        w_q[rk_base + WIDX_W'(2)], w_q[rk_base + WIDX_W'(3)]};

    aes_enc_round u_round (
        .state       (state_q),
        .round_key   (round_key),
        .final_round (final_round),
        .next_state  (round_out)
    );

`ifdef AES_KEY_CACHE_EN
    logic [32*Nk-1:0] key_cache_q;
    logic             cache_vld_q;

    assign cache_hit = cache_vld_q && (key == key_cache_q);

    // Cache flag: cleared when a new key starts expanding, set once it is complete
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cache_vld_q <= 1'b0;
        end else if (accept && !cache_hit) begin
            cache_vld_q <= 1'b0;
        end else if (fsm_q == KEYEXP && last_word) begin
            cache_vld_q <= 1'b1;
        end
    end

    // Remember which key the round-key storage belongs to
    always_ff @(posedge clk) begin
        if (accept && !cache_hit) begin
            key_cache_q <= key;
        end
    end
`else
    assign cache_hit = 1'b0;
`endif

    // Datapath storage (not reset): whitened state, round-key words
    always_ff @(posedge clk) begin
        if (accept) begin
            state_q <= pt ^ key[32*Nk-1 -: 128];
            if (!cache_hit) begin
                for (int j = 0; j < Nk; j++) begin
                    w_q[WIDX_W'(j)] <= key[32*(Nk-j)-1 -: 32];
                end
            end
        end else if (fsm_q == KEYEXP) begin
            w_q[widx_q] <= w_new;
        end else if (fsm_q == ROUND) begin
            state_q <= round_out;
        end
    end

    // Control FSM with registered handshake outputs and result register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q      <= IDLE;
            in_ready_q <= 1'b1;
            ct_valid_q <= 1'b0;
            ct_q       <= '0;
            widx_q     <= '0;
            kmod_q     <= '0;
            rcon_idx_q <= '0;
            round_q    <= '0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (accept) begin
                        in_ready_q <= 1'b0;
                        if (cache_hit) begin
                            fsm_q   <= ROUND;
                            round_q <= 4'd1;
                        end else begin
                            fsm_q      <= KEYEXP;
                            widx_q     <= WIDX_W'(Nk);
                            kmod_q     <= '0;
                            rcon_idx_q <= 4'd1;
                        end
                    end
                end
                KEYEXP: begin
                    widx_q <= widx_q + WIDX_W'(1);
                    if (kmod_last) begin
                        kmod_q     <= '0;
                        rcon_idx_q <= rcon_idx_q + 4'd1;
                    end else begin
                        kmod_q <= kmod_q + 3'd1;
                    end
                    if (last_word) begin
                        fsm_q   <= ROUND;
                        round_q <= 4'd1;
                    end
                end
                ROUND: begin
                    round_q <= round_q + 4'd1;
                    if (final_round) begin
                        fsm_q      <= DONE;
                        ct_q       <= round_out;
                        ct_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (ct_ready) begin
                        fsm_q      <= IDLE;
                        ct_valid_q <= 1'b0;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    fsm_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign ct_valid    = ct_valid_q;
    assign ct          = ct_q;
    assign dbg_state_o = fsm_q;

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// tb_aes_encrypt_iter: directed FIPS-197 vectors on Nk=4, 6 and 8 instances,
// plus hand-written sequences for hold, mid-operation reset, key cache
// (AES_KEY_CACHE_EN) and back-to-back operation.
module tb_aes_encrypt_iter;
    import aes_pkg::*;

    localparam logic [255:0] KA = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [127:0] PA = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CA = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [255:0] KC = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [127:0] PC = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [255:0] K6 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    localparam logic [127:0] C6 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [255:0] K8 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] C8 = 128'h8ea2b7ca516745bfeafc49904b496089;

`ifdef AES_KEY_CACHE_EN
    localparam int HIT_LAT = 10;
`else
    localparam int HIT_LAT = 50;
`endif

    typedef struct {
        int           d;
        logic [255:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
        int           lat;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [2:0]   in_valid_v;
    logic [255:0] key_bus;
    logic [127:0] pt_bus;
    logic         ct_ready;
    logic [2:0]   in_ready_w;
    logic [2:0]   ct_valid_w;
    logic [127:0] ct_w [3];
    logic [2:0]   dbg_w [3];

    int n_checks = 0;
    int n_fail   = 0;

    vec_t vecs [4];

    // clock/reset
    always #5 clk = ~clk;

    aes_encrypt_iter #(.Nk(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(in_ready_w[0]),
        .key(key_bus[255:128]), .pt(pt_bus), .ct_valid(ct_valid_w[0]),
        .ct_ready(ct_ready), .ct(ct_w[0]), .dbg_state_o(dbg_w[0])
    );

    aes_encrypt_iter #(.Nk(6)) dut6 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(in_ready_w[1]),
        .key(key_bus[255:64]), .pt(pt_bus), .ct_valid(ct_valid_w[1]),
        .ct_ready(ct_ready), .ct(ct_w[1]), .dbg_state_o(dbg_w[1])
    );

    aes_encrypt_iter #(.Nk(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[2]), .in_ready(in_ready_w[2]),
        .key(key_bus), .pt(pt_bus), .ct_valid(ct_valid_w[2]),
        .ct_ready(ct_ready), .ct(ct_w[2]), .dbg_state_o(dbg_w[2])
    );

    // scoreboard helpers
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%b expected=%b", name, act, exp);
        end
    endtask

    // driver tasks (all entered #1 after a rising edge)
    task automatic do_reset();
        rst        = 1'b1;
        in_valid_v = '0;
        ct_ready   = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic start_req(input int d, input logic [255:0] k, input logic [127:0] p);
        int t;
        t = 0;
        while (!in_ready_w[d] && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!in_ready_w[d]) check_bit("in_ready_timeout", in_ready_w[d], 1'b1);
        key_bus       = k;
        pt_bus        = p;
        in_valid_v[d] = 1'b1;
        @(posedge clk);
        #1 in_valid_v[d] = 1'b0;
    endtask

    task automatic wait_result(input int d, input string name, input logic [127:0] exp_ct,
                               input int exp_lat);
        int lat;
        lat = 0;
        while (!ct_valid_w[d] && lat < 300) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({name, "_latency"}, 128'(lat), 128'(exp_lat));
        check({name, "_ct"}, ct_w[d], exp_ct);
    endtask

    task automatic release_ct(input int d, input string name);
        ct_ready = 1'b1;
        @(posedge clk);
        #1 ct_ready = 1'b0;
        check_bit({name, "_rel_valid"}, ct_valid_w[d], 1'b0);
        check_bit({name, "_rel_ready"}, in_ready_w[d], 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nv;
        int ready_between;
        int n_abort;
        logic prev_valid;

        vecs[0] = '{d: 0, key: KA, pt: PA, ct: CA, lat: 50};
        vecs[1] = '{d: 2, key: K8, pt: PC, ct: C8, lat: 66};
        vecs[2] = '{d: 1, key: K6, pt: PC, ct: C6, lat: 58};
        vecs[3] = '{d: 0, key: KC, pt: PC, ct: CC, lat: 50};

        rst        = 1'b1;
        in_valid_v = '0;
        ct_ready   = 1'b0;
        key_bus    = '0;
        pt_bus     = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            check_bit("rst_ct_valid", ct_valid_w[d], 1'b0);
            check_bit("rst_in_ready", in_ready_w[d], 1'b1);
            check("rst_ct", ct_w[d], 128'h0);
            check("rst_state", 128'(dbg_w[d]), 128'(IDLE));
        end
        rst = 1'b0;
        @(posedge clk);
        #1;

        // table-driven FIPS-197 vectors
        for (int i = 0; i < 4; i++) begin
            start_req(vecs[i].d, vecs[i].key, vecs[i].pt);
            wait_result(vecs[i].d, $sformatf("vec%0d", i), vecs[i].ct, vecs[i].lat);
            release_ct(vecs[i].d, $sformatf("vec%0d", i));
        end

        // hold in DONE with ct_ready low; in_valid pulses must be ignored
        do_reset();
        start_req(0, KC, PC);
        wait_result(0, "hold", CC, 50);
        for (int k = 0; k < 5; k++) begin
            in_valid_v[0] = k[0];
            key_bus       = {8{$urandom()}};
            pt_bus        = {4{$urandom()}};
            @(posedge clk);
            #1;
            check("hold_ct", ct_w[0], CC);
            check_bit("hold_valid", ct_valid_w[0], 1'b1);
            check_bit("hold_in_ready", in_ready_w[0], 1'b0);
            check("hold_state", 128'(dbg_w[0]), 128'(DONE));
        end
        in_valid_v[0] = 1'b0;
        release_ct(0, "hold");
        check("hold_ct_kept", ct_w[0], CC);
        repeat (5) @(posedge clk);
        #1;
        check("hold_no_queue_state", 128'(dbg_w[0]), 128'(IDLE));
        check_bit("hold_no_queue_valid", ct_valid_w[0], 1'b0);

        // reset 20 edges into an operation
        start_req(0, KA, PA);
        repeat (20) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst_ct", ct_w[0], 128'h0);
        check_bit("midrst_valid", ct_valid_w[0], 1'b0);
        check_bit("midrst_in_ready", in_ready_w[0], 1'b1);
        @(posedge clk);
        #1 rst = 1'b0;
        n_abort = 0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk);
            #1;
            if (ct_valid_w[0]) n_abort++;
        end
        check("midrst_no_partial", 128'(n_abort), 128'h0);
        start_req(0, KA, PA);
        wait_result(0, "after_rst", CA, 50);
        release_ct(0, "after_rst");

        // same key twice, then a different key
        do_reset();
        start_req(0, KA, PA);
        wait_result(0, "cache_first", CA, 50);
        release_ct(0, "cache_first");
        start_req(0, KA, PA);
        wait_result(0, "cache_same", CA, HIT_LAT);
        release_ct(0, "cache_same");
        start_req(0, KC, PC);
        wait_result(0, "cache_new", CC, 50);
        release_ct(0, "cache_new");

        // back-to-back with ct_ready tied high
        do_reset();
        ct_ready      = 1'b1;
        key_bus       = KC;
        pt_bus        = PC;
        in_valid_v[0] = 1'b1;
        nv            = 0;
        ready_between = 0;
        prev_valid    = 1'b0;
        for (int k = 0; k < 600 && nv < 3; k++) begin
            @(posedge clk);
            #1;
            if (ct_valid_w[0]) begin
                nv++;
                check("b2b_ct", ct_w[0], CC);
                check_bit("b2b_single_pulse", prev_valid, 1'b0);
                if (nv > 1) check("b2b_ready_cycles", 128'(ready_between), 128'd1);
                ready_between = 0;
                if (nv == 3) in_valid_v[0] = 1'b0;
            end else if (in_ready_w[0]) begin
                ready_between++;
            end
            prev_valid = ct_valid_w[0];
        end
        in_valid_v[0] = 1'b0;
        check("b2b_results", 128'(nv), 128'd3);
        @(posedge clk);
        #1 ct_ready = 1'b0;
        check_bit("b2b_end_valid", ct_valid_w[0], 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_encrypt_iter.md
AES_ENCRYPT_ITER -- requirements
Module: aes_encrypt_iter

Interface
REQ-001 SHALL have parameter Nk, default 4, key length in 32-bit words; legal values are 4, 6 and 8.
REQ-002 SHALL have parameter Nr, default Nk+6, number of cipher rounds.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: pt and key are valid.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts a request.
REQ-007 SHALL have port key, input, 32*Nk bits: cipher key; the MSB word is w[0] (FIPS-197 order).
REQ-008 SHALL have port pt, input, 128 bits: plaintext; pt[127:120] is byte 0.
REQ-009 SHALL have port ct_valid, output, 1 bit: ct holds a result.
REQ-010 SHALL have port ct_ready, input, 1 bit: the consumer takes ct.
REQ-011 SHALL have port ct, output, 128 bits: ciphertext.

Function
REQ-012 SHALL implement FIPS-197 encryption, iteratively, with one round per cycle.
REQ-013 SHALL use a 3-bit FSM with states IDLE, KEYEXP, ROUND and DONE.
REQ-014 SHALL drive in_ready=1 only in IDLE and ct_valid=1 only in DONE.
REQ-015 SHALL, on an accept (in_valid & in_ready), load state <= pt ^ w[0..3], load w[0..Nk-1] from key into round-key storage, and go to KEYEXP.
REQ-016 SHALL, in KEYEXP, generate one word per cycle for i = Nk..4*(Nr+1)-1:
- w[i] = w[i-Nk] ^ temp.
- temp = SubWord(RotWord(w[i-1])) ^ Rcon[i/Nk] when i mod Nk = 0.
- temp = SubWord(w[i-1]) when Nk = 8 and i mod Nk = 4.
- temp = w[i-1] otherwise.
- After the last word, go to ROUND with round = 1.
REQ-017 SHALL, in ROUND, apply SubBytes, ShiftRows, MixColumns and AddRoundKey(w[4r..4r+3]) for rounds r = 1..Nr-1, omit MixColumns for r = Nr, and go to DONE after round Nr.
REQ-018 SHALL give a latency from the accept edge to ct_valid of (4*(Nr+1)-Nk)+Nr edges: 50 for Nk=4, 58 for Nk=6, 66 for Nk=8.
REQ-019 SHALL hold ct and ct_valid stable in DONE until ct_ready=1, then go to IDLE on that edge.
REQ-020 SHALL ignore in_valid while not in IDLE; no request is queued.
REQ-021 SHALL hold ct at its last result outside DONE.
REQ-022 SHALL keep the round counter 4 bits wide and the word index wide enough for 4*(Nr+1)-1, with no wrap inside one operation.

Reset
REQ-023 SHALL, while rst=1, force the FSM to IDLE and set ct=0, ct_valid=0, in_ready=1, and clear the counters and any cache-valid flag.
REQ-024 SHALL abort any operation in progress when reset is asserted mid-operation; no partial result appears after reset is released.
REQ-025 SHALL leave the round-key storage and state register contents undefined after reset; they are not reset.

Configuration
REQ-026 SHALL, with AES_KEY_CACHE_EN defined, store the last expanded key plus a valid flag, and on an accept whose key equals the stored key with the flag set, skip KEYEXP and go straight to ROUND; latency is then Nr edges.
REQ-027 SHALL, without AES_KEY_CACHE_EN, run KEYEXP on every accept and contain no key-compare logic.

Structure
REQ-028 SHALL place the S-box table or function, the Rcon table, xtime, the state_t typedef (128-bit) and the FSM enum in the shared package aes_pkg.
REQ-029 SHALL use one combinational sub-module, aes_enc_round, with inputs state, round_key and final_round, and output next_state; aes_encrypt_iter instantiates it once.

Verification
REQ-030 SHALL cover: Nk=4, key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> ct 3925841d02dc09fbdc118597196a0b32, with ct_valid exactly 50 edges after accept.
REQ-031 SHALL cover: Nk=8, key 000102..1f, pt 00112233445566778899aabbccddeeff -> ct 8ea2b7ca516745bfeafc49904b496089 at 66 edges.
REQ-032 SHALL cover: Nk=4, key 000102..0f, same pt -> ct 69c4e0d86a7b0430d8cdb78070b4c55a; hold ct_ready=0 for 5 cycles -> ct and ct_valid stable; in_valid pulses during that time are ignored.
REQ-033 SHALL cover: rst pulse at edge 20 of an operation -> ct=0 and ct_valid=0 immediately; a new request afterwards completes correctly at 50 edges.
REQ-034 SHALL cover: with AES_KEY_CACHE_EN, two back-to-back requests with the same key -> the second ct is correct after 10 edges; a third request with a different key takes 50 edges.
REQ-035 SHALL cover: with ct_ready tied to 1 and requests issued back-to-back -> exactly one in_ready cycle between results and no lost or duplicated ct_valid.
